// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: command port and status outputs of the interval timer
interface timer_sequencer_if #(
   parameter int CNT_W = 8,
   parameter int PRE_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;
   logic             cmd_periodic;
   logic [PRE_W-1:0] pre_div;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             paused;
   logic             done;
   logic             err;
   logic [7:0]       periods;
   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_periodic, pre_div,
      input  cmd_ready, count, busy, paused, done, err, periods
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_periodic, pre_div,
      output cmd_ready, count, busy, paused, done, err, periods
   );
endinterface

// File: rtl/timer_sequencer.sv
// timer_sequencer: one-shot/periodic interval timer controller; TIMER_SEQ_PRESCALE_EN adds a step prescaler
module timer_sequencer #(
   parameter int CNT_W = 8,
   parameter int PRE_W = 4
) (
   input logic              clk,
   input logic              rst,
   timer_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   localparam logic [1:0] OP_START = 2'b00, OP_PAUSE = 2'b01, OP_RESUME = 2'b10;
   state_t           state;
   logic [CNT_W-1:0] len_q;
   logic             periodic_q;
   logic             acc;
   logic             bad;
   logic             tick;
   logic             term;
`ifdef TIMER_SEQ_PRESCALE_EN
   logic [PRE_W-1:0] pre;
   logic [PRE_W-1:0] div_q;
`endif
   // decode the accepted command, its legality, and whether this cycle may step
   always_comb begin
      acc  = bus.cmd_valid && bus.cmd_ready;
      bad  = (bus.cmd_op == OP_START && (bus.cmd_len == '0 || state != IDLE)) ||
             (bus.cmd_op == OP_PAUSE && state != RUN) ||
             (bus.cmd_op == OP_RESUME && state != PAUSE);
`ifdef TIMER_SEQ_PRESCALE_EN
      tick = pre == div_q;
`else
      tick = 1'b1;
`endif
      term = bus.count == len_q - 1'b1;
   end
   // controller FSM; any accepted command (legal or not) suppresses the step on its edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         len_q         <= '0;
         periodic_q    <= 1'b0;
         bus.cmd_ready <= 1'b0;
         bus.count     <= '0;
         bus.busy      <= 1'b0;
         bus.paused    <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.periods   <= '0;
`ifdef TIMER_SEQ_PRESCALE_EN
         pre           <= '0;
         div_q         <= '0;
`endif
      end else begin
         bus.cmd_ready <= 1'b1;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         if (acc && bad) begin
            bus.err <= 1'b1;
         end else if (acc) begin
            case (bus.cmd_op)
               OP_START: begin
                  state       <= RUN;
                  bus.busy    <= 1'b1;
                  bus.count   <= '0;
                  bus.periods <= '0;
                  len_q       <= bus.cmd_len;
                  periodic_q  <= bus.cmd_periodic;
`ifdef TIMER_SEQ_PRESCALE_EN
                  pre         <= '0;
                  div_q       <= bus.pre_div;
`endif
               end
               OP_PAUSE: begin
                  state      <= PAUSE;
                  bus.paused <= 1'b1;
               end
               OP_RESUME: begin
                  state      <= RUN;
                  bus.paused <= 1'b0;
               end
               default: begin
                  state      <= IDLE;
                  bus.busy   <= 1'b0;
                  bus.paused <= 1'b0;
                  bus.count  <= '0;
`ifdef TIMER_SEQ_PRESCALE_EN
                  pre        <= '0;
`endif
               end
            endcase
         end else if (state == RUN) begin
`ifdef TIMER_SEQ_PRESCALE_EN
            pre <= tick ? '0 : pre + 1'b1;
`endif
            if (tick && term) begin
               bus.count   <= '0;
               bus.done    <= 1'b1;
               bus.periods <= bus.periods + 1'b1;
               if (!periodic_q) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end else if (tick) begin
               bus.count <= bus.count + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: scoreboard bench for timer_sequencer, one task per scenario
module tb_timer_sequencer;
   localparam logic [1:0] ST = 2'b00, PA = 2'b01, RE = 2'b10, AB = 2'b11;
   typedef struct packed {
      logic       rdy;
      logic [7:0] count;
      logic       busy;
      logic       paused;
      logic       done;
      logic       err;
      logic [7:0] periods;
   } snap_t;
   logic   clk;
   logic   rst;
   snap_t  q[$];
   snap_t  e;
   snap_t  s;
   int     n_cmp;
   int     n_bad;
   timer_sequencer_if #(.CNT_W(8), .PRE_W(4)) bus ();
   timer_sequencer #(.CNT_W(8), .PRE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic snap_t mk(input logic r, input int c, input logic b, input logic p, input logic d, input logic er, input int per);
      return '{r, c[7:0], b, p, d, er, per[7:0]};
   endfunction
   function automatic snap_t obs();
      return '{bus.cmd_ready, bus.count, bus.busy, bus.paused, bus.done, bus.err, bus.periods};
   endfunction
   task automatic cmd(input logic v, input logic [1:0] op, input int len, input logic per, input int div);
      bus.cmd_valid    = v;
      bus.cmd_op       = op;
      bus.cmd_len      = len[7:0];
      bus.cmd_periodic = per;
      bus.pre_div      = div[3:0];
   endtask
   task automatic test_reset();
      rst = 1'b1;
      cmd(1'b0, ST, 0, 1'b0, 0);
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         rst = (i < 2);
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL reset[%0d] got %p want %p", i, s, e); end
      end
   endtask
   task automatic test_oneshot();
      q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
      for (int k = 1; k <= 4; k++) q.push_back(mk(1, k, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 1, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < 7; i++) begin
         cmd(i == 0, ST, 5, 1'b0, 0);
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL oneshot[%0d] got %p want %p", i, s, e); end
      end
   endtask
   task automatic test_periodic();
      for (int k = 0; k <= 10; k++) q.push_back(mk(1, k % 3, 1, 0, k > 0 && k % 3 == 0, 0, k / 3));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 3));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 3));
      for (int i = 0; i < 13; i++) begin
         cmd(i == 0 || i == 11, i == 11 ? AB : ST, 3, 1'b1, 0);
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL periodic[%0d] got %p want %p", i, s, e); end
      end
   endtask
   task automatic test_pause();
      int  st;
      logic stepped;
      st = 0;
      for (int i = 0; i < 13; i++) begin
         stepped = i > 0 && (i < 3 || i > 7) && st < 6;
         st += int'(stepped);
         q.push_back(mk(1, st % 6, st < 6, i >= 3 && i < 7, stepped && st == 6, 0, int'(st == 6)));
      end
      for (int i = 0; i < 13; i++) begin
         cmd(i == 0 || i == 3 || i == 7, i == 3 ? PA : i == 7 ? RE : ST, 6, 1'b0, 0);
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL pause[%0d] got %p want %p", i, s, e); end
      end
   endtask
   task automatic test_errors();
      q.push_back(mk(1, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 1, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      for (int k = 0; k <= 3; k++) q.push_back(mk(1, k, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 3, 1, 0, 0, 1, 0));
      q.push_back(mk(1, 4, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 13; i++) begin
         case (i)
            0:       cmd(1'b1, ST, 0, 1'b0, 0);
            2:       cmd(1'b1, RE, 4, 1'b0, 0);
            3:       cmd(1'b1, PA, 4, 1'b0, 0);
            5:       cmd(1'b1, ST, 8, 1'b0, 0);
            9:       cmd(1'b1, ST, 2, 1'b1, 0);
            11:      cmd(1'b1, AB, 0, 1'b0, 0);
            default: cmd(1'b0, ST, 0, 1'b0, 0);
         endcase
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL errors[%0d] got %p want %p", i, s, e); end
      end
   endtask
   task automatic test_boundary();
      q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 1, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 1, 1, 1, 0, 0, 0));
      q.push_back(mk(1, 1, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 1, 0, 1, 0, 1));
      q.push_back(mk(1, 1, 1, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 1, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < 11; i++) begin
         case (i)
            0:       cmd(1'b1, ST, 2, 1'b1, 0);
            2:       cmd(1'b1, PA, 0, 1'b0, 0);
            3:       cmd(1'b1, RE, 0, 1'b0, 0);
            6:       cmd(1'b1, AB, 0, 1'b0, 0);
            8:       cmd(1'b1, ST, 1, 1'b0, 0);
            default: cmd(1'b0, ST, 0, 1'b0, 0);
         endcase
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL boundary[%0d] got %p want %p", i, s, e); end
      end
   endtask
   task automatic test_prescale();
      int   d;
      int   st;
      logic stepped;
`ifdef TIMER_SEQ_PRESCALE_EN
      d = 2;
`else
      d = 0;
`endif
      st = 0;
      for (int k = 0; k < 8; k++) begin
         stepped = k > 0 && k % (d + 1) == 0 && st < 2;
         st += int'(stepped);
         q.push_back(mk(1, st % 2, st < 2, 0, stepped && st == 2, 0, int'(st == 2)));
      end
      for (int i = 0; i < 8; i++) begin
         cmd(i == 0, ST, 2, 1'b0, 2);
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL prescale[%0d] got %p want %p", i, s, e); end
      end
   endtask
   task automatic test_reset_mid();
      q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 1, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 2, 1, 0, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 6; i++) begin
         cmd(i == 0, ST, 5, 1'b1, 0);
         rst = (i == 3);
         @(posedge clk); #1;
         s = obs(); e = q.pop_front(); n_cmp++;
         if (s !== e) begin n_bad++; $display("FAIL reset_mid[%0d] got %p want %p", i, s, e); end
      end
      rst = 1'b0;
   endtask
   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_pause();
      test_errors();
      test_boundary();
      test_prescale();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Controller that sequences a shared up-counter datapath as a one-shot or periodic interval timer. Software-side logic issues START / PAUSE / RESUME / ABORT commands over a valid/ready port. The block runs the counter through a programmed length and signals each terminal count with a one-cycle `done` pulse. It sits between the control logic and the free-running counters used across our FPGA examples, replacing ad-hoc reset-driven counting.

## Interface
- `CNT_W`, default 8: counter and length width.
- `PRE_W`, default 4: prescaler divide-field width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 2: 00 START, 01 PAUSE, 10 RESUME, 11 ABORT.
- `cmd_len` in CNT_W: terminal length L for START; must be ≥1.
- `cmd_periodic` in 1: with START, 1 = periodic, 0 = one-shot.
- `pre_div` in PRE_W: prescale divide-minus-one, latched at START. Ignored unless the prescaler macro is defined.
- `count` out CNT_W: current count, 0..L-1.
- `busy` out 1: state is RUN or PAUSE.
- `paused` out 1: state is PAUSE.
- `done` out 1: one-cycle pulse on each terminal count.
- `err` out 1: one-cycle pulse on an illegal command.
- `periods` out 8: completed terminal counts since the last START; wraps 255→0.

## Operation
- Registered outputs only. Reset values: `cmd_ready`=0, `count`=0, `busy`=0, `paused`=0, `done`=0, `err`=0, `periods`=0, state IDLE, latched length/mode/divider 0.
- `cmd_ready` goes to 1 on the first edge after `rst` deasserts and stays 1 until the next reset.
- States and transitions:
  - IDLE → RUN on START with L≥1. The edge clears `count`, `periods` and the prescaler, and latches L, mode and `pre_div`.
  - RUN → PAUSE on PAUSE. `count` and the prescaler hold.
  - PAUSE → RUN on RESUME.
  - Any state → IDLE on ABORT. `count` is cleared, `done` is not pulsed, `periods` holds.
- Step: in RUN, every cycle in which no command is accepted.
  - If `count` < L-1: `count`+1.
  - If `count` == L-1 (terminal): `count` goes to 0, `done`=1 next cycle, `periods`+1. A one-shot timer goes to IDLE; a periodic timer stays in RUN.
- Illegal commands produce an `err` pulse with no state change:
  - START with L=0.
  - START while RUN or PAUSE.
  - PAUSE outside RUN.
  - RESUME outside PAUSE.
- Accepted commands have priority over the step. No step occurs on an edge that accepts any command.
  - ABORT coinciding with a terminal step: no `done`.
  - PAUSE on a terminal-count cycle: the count holds at L-1, and the terminal step completes after RESUME.
- `rst` asserted mid-operation: all outputs return to their reset values on that edge, and any pending step is discarded.

## Timing
- START accepted at edge N: `count` becomes 1 at edge N+1 and k at edge N+k.
- `done` is high for the single cycle following edge N+L.
- Periodic mode: `done` repeats every L cycles exactly, with no dead cycle.
- Each accepted PAUSE…RESUME pair (PAUSE accepted at edge P, RESUME at edge R) delays all subsequent events by R−P+1 cycles.
- `err` is high for the single cycle after the offending edge.

## Configuration
- `TIMER_SEQ_PRESCALE_EN` defined:
  - A step occurs only on cycles where the internal prescaler equals the latched `pre_div`.
  - The prescaler counts 0..`pre_div` in RUN and wraps to 0 on each step.
  - The prescaler clears on START and ABORT, and holds in PAUSE.
  - Period becomes L·(`pre_div`+1).
- `TIMER_SEQ_PRESCALE_EN` undefined: no prescaler logic; every RUN cycle without a command is a step, and `pre_div` is unconnected.

## Test plan
- Reset: hold `rst` 2 cycles, then release → all outputs 0 during reset, `cmd_ready`=1 one edge after release.
- One-shot: START L=5 at edge N → `count` 1,2,3,4 at N+1..N+4, 0 at N+5; `done` high one cycle after N+5; `busy`=0; `periods`=1.
- Periodic: START L=3 periodic, run 10 cycles, then ABORT → `done` every 3 cycles (3 pulses); `periods`=3; no `done` after ABORT; `count`=0.
- Pause: START L=6, PAUSE when `count`=2, RESUME 4 edges later (R−P=4) → `count` frozen at 2, `paused`=1 throughout; `done` arrives 5 cycles later than the unpaused case.
- Errors: START L=0 → `err` pulse, stays IDLE. START while RUN with `count`=3 → `err` pulse, count continues to 4. RESUME in IDLE → `err` pulse.
- Prescaler, macro defined: START L=2, `pre_div`=2 → `count`=1 at N+3, `done` one cycle after N+6, `periods`=1.
